// File: rtl/sr_pattern_driver_if.sv
// Bundle of the pattern-load handshake and the SR flop excitation/feedback
// signals exchanged between the pattern driver and its environment.
interface sr_pattern_driver_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH);

    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] pattern;
    logic             s;
    logic             r;
    logic             q_fb;
    logic             qb_fb;
    logic             q_exp;
    logic             busy;
    logic             done;
    logic             err;
    logic [IW-1:0]    err_idx;

    // Pattern source and SR flop side
    modport master (
        output load_valid,
        output pattern,
        output q_fb,
        output qb_fb,
        input  load_ready,
        input  s,
        input  r,
        input  q_exp,
        input  busy,
        input  done,
        input  err,
        input  err_idx
    );

    // Pattern driver side
    modport slave (
        input  load_valid,
        input  pattern,
        input  q_fb,
        input  qb_fb,
        output load_ready,
        output s,
        output r,
        output q_exp,
        output busy,
        output done,
        output err,
        output err_idx
    );
endinterface

// File: rtl/sr_pattern_driver.sv
// SR pattern driver: accepts a WIDTH-bit target pattern, plays it LSB first
// into an external SR flop as S/R excitation pairs, reads q/qb back after each
// bit and records the index of the first mismatch in a sticky error flag.
module sr_pattern_driver #(
    parameter int WIDTH    = 8,
    parameter bit CHECK_QB = 1'b1
) (
    input logic            clk,
    input logic            reset,
    sr_pattern_driver_if.slave bus
);
    localparam int            IW       = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        CHECK,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pat_q;
    logic [IW-1:0]    idx;
    logic             s_q;
    logic             r_q;
    logic             q_exp_q;
    logic             load_ready_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;
    logic [IW-1:0]    err_idx_q;

    logic [IW-1:0]    idx_next;
    logic             bit_next;
    logic             mismatch;

    assign idx_next = idx + IW'(1);
    assign bit_next = pat_q[idx_next];
    assign mismatch = (bus.q_fb != q_exp_q) | (CHECK_QB & (bus.qb_fb != ~q_exp_q));

    // Sequencer: the S/R pair for a bit is registered on the edge entering
    // DRIVE so it is stable for the whole DRIVE cycle; the flop is then read
    // back on the edge that closes the following CHECK cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            pat_q        <= '0;
            idx          <= '0;
            s_q          <= 1'b0;
            r_q          <= 1'b0;
            q_exp_q      <= 1'b0;
            load_ready_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_idx_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    s_q          <= 1'b0;
                    r_q          <= 1'b0;
                    done_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                    if (bus.load_valid && load_ready_q) begin
                        pat_q        <= bus.pattern;
                        idx          <= '0;
                        err_q        <= 1'b0;
                        err_idx_q    <= '0;
                        busy_q       <= 1'b1;
                        load_ready_q <= 1'b0;
                        // Bit 0 is always driven so the flop state is known
                        // regardless of what q_exp held from earlier loads.
                        s_q          <= bus.pattern[0];
                        r_q          <= ~bus.pattern[0];
                        state        <= DRIVE;
                    end
                end
                DRIVE: begin
                    q_exp_q <= pat_q[idx];
                    s_q     <= 1'b0;
                    r_q     <= 1'b0;
                    state   <= CHECK;
                end
                CHECK: begin
                    if (mismatch && !err_q) begin
                        err_q     <= 1'b1;
                        err_idx_q <= idx;
                    end
                    if (idx == LAST_IDX) begin
                        done_q <= 1'b1;
                        state  <= DONE;
                    end else begin
                        idx <= idx_next;
                        // Only excite the flop when the next bit changes its
                        // state; otherwise leave S=R=0 so it holds.
                        if (bit_next != q_exp_q) begin
                            s_q <= bit_next;
                            r_q <= ~bit_next;
                        end
                        state <= DRIVE;
                    end
                end
                DONE: begin
                    done_q       <= 1'b0;
                    busy_q       <= 1'b0;
                    load_ready_q <= 1'b1;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.load_ready = load_ready_q;
    assign bus.s          = s_q;
    assign bus.r          = r_q;
    assign bus.q_exp      = q_exp_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.err_idx    = err_idx_q;
endmodule
